// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: the in-flight entry layout and the
// rule for capturing an entry from the ID stage.
package hazard_scoreboard_pkg;

  localparam int unsigned REG_W      = 5;
  localparam int unsigned NUM_STAGES = 3;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic             is_load;
    logic             is_mfc0;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  // Writes to $0 (or non-writing instructions) never become hazards; all fields stay zero.
  function automatic sb_entry_t sb_capture(input logic             reg_wr,
                                           input logic [REG_W-1:0] dst,
                                           input logic             is_load,
                                           input logic             is_mfc0);
    sb_entry_t e;
    e = SB_BUBBLE;
    if (reg_wr && (dst != '0)) begin
      e.valid   = 1'b1;
      e.dst     = dst;
      e.is_load = is_load;
      e.is_mfc0 = is_mfc0;
    end
    return e;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side bundle of the hazard scoreboard: ID issue info, stage control,
// stall inputs for counting, and the per-stage hazard outputs and counters.
interface hazard_scoreboard_if #(
  parameter int unsigned CNT_W = 16
);

  localparam int unsigned REG_W = hazard_scoreboard_pkg::REG_W;

  logic             ID_Issue;
  logic [REG_W-1:0] ID_Dst;
  logic             ID_RegWr;
  logic             ID_IsLoad;
  logic             ID_IsMFC0;

  logic             EXE_Wr;
  logic             MEM_Wr;
  logic             MEM2_Wr;
  logic             EXE_Flush;
  logic             MEM_Flush;
  logic             MEM2_Flush;

  logic             ID_EX_DH_Stall;
  logic             ID_MEM1_DH_Stall;
  logic             ID_MEM2_DH_Stall;
  logic             Cnt_Clr;

  logic [REG_W-1:0] EXE_rt;
  logic [REG_W-1:0] MEM_rt;
  logic [REG_W-1:0] MEM2_rt;
  logic             EXE_ReadMEM;
  logic             MEM_ReadMEM;
  logic             MEM2_ReadMEM;
  logic             EXE_IsMFC0;
  logic             MEM_IsMFC0;

  logic [CNT_W-1:0] Cnt_EX;
  logic [CNT_W-1:0] Cnt_MEM1;
  logic [CNT_W-1:0] Cnt_MEM2;

  modport master (
    output ID_Issue, ID_Dst, ID_RegWr, ID_IsLoad, ID_IsMFC0,
    output EXE_Wr, MEM_Wr, MEM2_Wr, EXE_Flush, MEM_Flush, MEM2_Flush,
    output ID_EX_DH_Stall, ID_MEM1_DH_Stall, ID_MEM2_DH_Stall, Cnt_Clr,
    input  EXE_rt, MEM_rt, MEM2_rt,
    input  EXE_ReadMEM, MEM_ReadMEM, MEM2_ReadMEM,
    input  EXE_IsMFC0, MEM_IsMFC0,
    input  Cnt_EX, Cnt_MEM1, Cnt_MEM2
  );

  modport slave (
    input  ID_Issue, ID_Dst, ID_RegWr, ID_IsLoad, ID_IsMFC0,
    input  EXE_Wr, MEM_Wr, MEM2_Wr, EXE_Flush, MEM_Flush, MEM2_Flush,
    input  ID_EX_DH_Stall, ID_MEM1_DH_Stall, ID_MEM2_DH_Stall, Cnt_Clr,
    output EXE_rt, MEM_rt, MEM2_rt,
    output EXE_ReadMEM, MEM_ReadMEM, MEM2_ReadMEM,
    output EXE_IsMFC0, MEM_IsMFC0,
    output Cnt_EX, Cnt_MEM1, Cnt_MEM2
  );

endinterface

// File: rtl/sb_stage_reg.sv
// One scoreboard slot: flush clears, advance takes the upstream entry only if
// upstream also advances (otherwise a bubble), else the entry holds.
module sb_stage_reg
  import hazard_scoreboard_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      wr,
  input  logic      up_adv,
  input  sb_entry_t up_entry,
  output sb_entry_t entry
);

  sb_entry_t entry_d;
  sb_entry_t entry_q;

  always_comb begin
    entry_d = entry_q;
    if (flush) begin
      entry_d = SB_BUBBLE;
    end else if (wr) begin
      entry_d = up_adv ? up_entry : SB_BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= SB_BUBBLE;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry = entry_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker for EXE/MEM/MEM2 feeding the ID hazard detector,
// plus saturating stall-cycle counters per hazard source.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sb_entry_t id_entry_c;
  sb_entry_t exe_entry;
  sb_entry_t mem_entry;
  sb_entry_t mem2_entry;

  assign id_entry_c = sb_capture(sb.ID_RegWr, sb.ID_Dst, sb.ID_IsLoad, sb.ID_IsMFC0);

  sb_stage_reg u_exe (
    .clk      (clk),
    .rst      (rst),
    .flush    (sb.EXE_Flush),
    .wr       (sb.EXE_Wr),
    .up_adv   (sb.ID_Issue),
    .up_entry (id_entry_c),
    .entry    (exe_entry)
  );

  sb_stage_reg u_mem (
    .clk      (clk),
    .rst      (rst),
    .flush    (sb.MEM_Flush),
    .wr       (sb.MEM_Wr),
    .up_adv   (sb.EXE_Wr),
    .up_entry (exe_entry),
    .entry    (mem_entry)
  );

  sb_stage_reg u_mem2 (
    .clk      (clk),
    .rst      (rst),
    .flush    (sb.MEM2_Flush),
    .wr       (sb.MEM2_Wr),
    .up_adv   (sb.MEM_Wr),
    .up_entry (mem_entry),
    .entry    (mem2_entry)
  );

  // MFC0 is already resolved by MEM2, so that bit is carried but never observed.
  logic unused_mem2_mfc0;
  assign unused_mem2_mfc0 = &{1'b0, mem2_entry.is_mfc0};

  assign sb.EXE_rt       = exe_entry.valid  ? exe_entry.dst  : '0;
  assign sb.MEM_rt       = mem_entry.valid  ? mem_entry.dst  : '0;
  assign sb.MEM2_rt      = mem2_entry.valid ? mem2_entry.dst : '0;
  assign sb.EXE_ReadMEM  = exe_entry.valid  & exe_entry.is_load;
  assign sb.MEM_ReadMEM  = mem_entry.valid  & mem_entry.is_load;
  assign sb.MEM2_ReadMEM = mem2_entry.valid & mem2_entry.is_load;
  assign sb.EXE_IsMFC0   = exe_entry.valid  & exe_entry.is_mfc0;
  assign sb.MEM_IsMFC0   = mem_entry.valid  & mem_entry.is_mfc0;

  // Stall-cycle counters: clear beats increment, saturate at all-ones.
  logic [CNT_W-1:0] cnt_ex_d,   cnt_ex_q;
  logic [CNT_W-1:0] cnt_mem1_d, cnt_mem1_q;
  logic [CNT_W-1:0] cnt_mem2_d, cnt_mem2_q;

  always_comb begin
    cnt_ex_d   = cnt_ex_q;
    cnt_mem1_d = cnt_mem1_q;
    cnt_mem2_d = cnt_mem2_q;
    if (sb.Cnt_Clr) begin
      cnt_ex_d   = '0;
      cnt_mem1_d = '0;
      cnt_mem2_d = '0;
    end else begin
      if (sb.ID_EX_DH_Stall && (cnt_ex_q != CNT_MAX)) begin
        cnt_ex_d = cnt_ex_q + CNT_W'(1);
      end
      if (sb.ID_MEM1_DH_Stall && (cnt_mem1_q != CNT_MAX)) begin
        cnt_mem1_d = cnt_mem1_q + CNT_W'(1);
      end
      if (sb.ID_MEM2_DH_Stall && (cnt_mem2_q != CNT_MAX)) begin
        cnt_mem2_d = cnt_mem2_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_ex_q <= '0;
    end else begin
      cnt_ex_q <= cnt_ex_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_mem1_q <= '0;
    end else begin
      cnt_mem1_q <= cnt_mem1_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_mem2_q <= '0;
    end else begin
      cnt_mem2_q <= cnt_mem2_d;
    end
  end

  assign sb.Cnt_EX   = cnt_ex_q;
  assign sb.Cnt_MEM1 = cnt_mem1_q;
  assign sb.Cnt_MEM2 = cnt_mem2_q;

endmodule
